store_narrow: RTL and testbench

Store-side lane packer and write buffer between the EX/MEM pipeline stage and the data memory. It narrows a 32-bit register value to byte, halfword or word width. It shifts that value onto the addressed byte lanes and generates per-byte write enables, which is the inverse of the load-side immediate/data extension. Accepted stores are queued in a small FIFO and drained to memory through a valid/ready handshake. Misaligned or illegal-size stores are rejected and flagged.

---
 rtl/store_narrow_pkg.sv | 19 +
 rtl/store_narrow_if.sv | 30 +++
 rtl/store_narrow_lane_pack.sv | 44 ++++
 rtl/store_narrow.sv | 106 ++++++++++
 tb/tb_store_narrow.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/store_narrow_pkg.sv
// Shared types and size encodings for the store-side lane packer and write buffer.
package store_pkg;

   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam logic [1:0] SZ_ILL = 2'b11;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } st_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/store_narrow_if.sv
// Request side (from EX/MEM) and drain side (to data memory) of the store buffer.
interface store_narrow_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_addr;
   logic [31:0]   in_data;
   logic [1:0]    in_size;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_addr;
   logic [3:0]    out_be;
   logic [31:0]   out_data;
   logic          out_exc;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_addr, in_data, in_size, out_ready,
      input  in_ready, out_valid, out_addr, out_be, out_data, out_exc, count
   );

   modport slave (
      input  in_valid, in_addr, in_data, in_size, out_ready,
      output in_ready, out_valid, out_addr, out_be, out_data, out_exc, count
   );

endinterface

// File: rtl/store_narrow_lane_pack.sv
// Replicates the narrow store value across all lanes and selects the byte enables
// for the addressed lanes; flags illegal sizes and misaligned half/word stores.
module lane_pack
   import store_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] in_data,
   output logic [3:0]  be,
   output logic [31:0] data,
   output logic        misalign
);

   // Lane selection and alignment check per store width
   always_comb begin
      be       = 4'b0000;
      data     = 32'h0000_0000;
      misalign = 1'b1;
      case (size)
         SZ_B: begin
            be       = 4'b0001 << addr_lo;
            data     = {4{in_data[7:0]}};
            misalign = 1'b0;
         end
         SZ_H: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            data     = {2{in_data[15:0]}};
            misalign = addr_lo[0];
         end
         SZ_W: begin
            be       = 4'b1111;
            data     = in_data;
            misalign = (addr_lo != 2'b00);
         end
         SZ_ILL: begin
            misalign = 1'b1;
         end
         default: begin
            misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_narrow.sv
// Store lane packer plus in-order write buffer drained to data memory over valid/ready.
module store_narrow
   import store_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   store_narrow_if.slave bus
);

   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_0   = {CW{1'b0}};

   st_entry_t     mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          ready_r;
   logic          exc_r;

   logic [3:0]    be_s;
   logic [31:0]   data_s;
   logic          misalign_s;
   logic          ready_s;
   logic          hs_s;
   logic          push_s;
   logic          pop_s;
   st_entry_t     entry_s;
   st_entry_t     head_s;

   lane_pack u_lane_pack (
      .addr_lo  (bus.in_addr[1:0]),
      .size     (bus.in_size),
      .in_data  (bus.in_data),
      .be       (be_s),
      .data     (data_s),
      .misalign (misalign_s)
   );

   // Handshake qualification; rejected stores still consume the handshake
   always_comb begin
      ready_s      = ready_r & ~reset;
      hs_s         = bus.in_valid & ready_s;
      push_s       = hs_s & ~misalign_s;
      pop_s        = (count_r != CNT_0) & bus.out_ready;
      entry_s.addr = word_align(bus.in_addr);
      entry_s.be   = be_s;
      entry_s.data = data_s;
   end

   // Occupancy next-state: simultaneous push and pop leaves it unchanged
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy, registered ready and the exception pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= CNT_0;
         ready_r  <= 1'b1;
         exc_r    <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_nxt_s;
         // Ready follows the updated occupancy, so a pop while full frees a slot next cycle
         ready_r <= (count_nxt_s < DEPTH_C);
         exc_r   <= hs_s & misalign_s;
      end
   end

   // Entry storage; contents need no reset since out_valid masks them
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= entry_s;
      end
   end

   // Drain side is driven purely from registered state
   always_comb begin
      head_s        = mem_r[rd_ptr_r];
      bus.in_ready  = ready_s;
      bus.out_valid = (count_r != CNT_0);
      bus.out_addr  = head_s.addr;
      bus.out_be    = head_s.be;
      bus.out_data  = head_s.data;
      bus.out_exc   = exc_r;
      bus.count     = count_r;
   end

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: stimulus pushes hand-computed entries to a scoreboard,
// an independent monitor pops and compares whenever memory takes the head entry.
module tb_store_narrow;
   import store_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   store_narrow_if #(.DEPTH(DEPTH)) bus ();

   store_narrow #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int        checks   = 0;
   int        failures = 0;
   st_entry_t sb [$];
   logic      cur_rej  = 1'b0;
   logic      rej_pend = 1'b0;
   logic      exp_exc  = 1'b0;
   logic      hold_v   = 1'b0;
   st_entry_t hold_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
      end
   endtask

   // A rejected handshake seen this cycle must give an out_exc pulse next cycle
   always @(negedge clk) rej_pend <= bus.in_valid && bus.in_ready && cur_rej && !reset;
   always @(posedge clk) exp_exc <= reset ? 1'b0 : rej_pend;

   // Monitor: exception pulse, head stability while stalled, in-order drain
   always @(negedge clk) begin
      st_entry_t e;
      if (reset) begin
         hold_v <= 1'b0;
      end else begin
         check("out_exc", 32'(bus.out_exc), 32'(exp_exc));
         if (bus.out_valid) begin
            if (hold_v) begin
               check("hold_addr", bus.out_addr, hold_e.addr);
               check("hold_be", 32'(bus.out_be), 32'(hold_e.be));
               check("hold_data", bus.out_data, hold_e.data);
            end
            if (bus.out_ready) begin
               hold_v <= 1'b0;
               if (sb.size() == 0) begin
                  check("unexpected_pop", 32'(1), 32'(0));
               end else begin
                  e = sb.pop_front();
                  check("out_addr", bus.out_addr, e.addr);
                  check("out_be", 32'(bus.out_be), 32'(e.be));
                  check("out_data", bus.out_data, e.data);
               end
            end else begin
               hold_v      <= 1'b1;
               hold_e.addr <= bus.out_addr;
               hold_e.be   <= bus.out_be;
               hold_e.data <= bus.out_data;
            end
         end else begin
            hold_v <= 1'b0;
         end
      end
   end

   // Called at a rising edge; returns at the rising edge where the handshake happens
   task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                       input logic ok, input logic [31:0] eaddr, input logic [3:0] ebe,
                       input logic [31:0] edata);
      int   n    = 0;
      logic done = 1'b0;
      st_entry_t e;
      #1;
      bus.in_valid = 1'b1;
      bus.in_addr  = addr;
      bus.in_data  = data;
      bus.in_size  = size;
      cur_rej      = !ok;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1'b1;
            if (ok) begin
               e.addr = eaddr;
               e.be   = ebe;
               e.data = edata;
               sb.push_back(e);
            end
         end else begin
            n++;
            if (n > 40) begin
               check("in_ready_timeout", 32'(0), 32'(1));
               done = 1'b1;
            end
         end
         @(posedge clk);
      end
   endtask

   task automatic idle();
      #1;
      bus.in_valid = 1'b0;
      cur_rej      = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_addr   = 32'h0;
      bus.in_data   = 32'h0;
      bus.in_size   = SZ_B;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", 32'(bus.in_ready), 32'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_count", 32'(bus.count), 32'(0));
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_out_exc", 32'(bus.out_exc), 32'(0));
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));

      // Byte store to lane 3, visible the next cycle
      @(posedge clk);
      bus.out_ready = 1'b1;
      send(32'h0000_0003, 32'h1234_56AB, SZ_B, 1'b1, 32'h0000_0000, 4'b1000, 32'hABAB_ABAB);
      idle();
      @(negedge clk);
      check("lat_out_valid", 32'(bus.out_valid), 32'(1));
      check("lat_count", 32'(bus.count), 32'(1));
      repeat (2) @(posedge clk);

      // Halfword stores to upper and lower halves
      send(32'h0000_1002, 32'hFFFF_8001, SZ_H, 1'b1, 32'h0000_1000, 4'b1100, 32'h8001_8001);
      send(32'h0000_2000, 32'h0000_BEEF, SZ_H, 1'b1, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF);
      idle();
      repeat (3) @(posedge clk);

      // Back-to-back rejected stores: misaligned word, misaligned half, illegal size
      send(32'h0000_0006, 32'h1111_1111, SZ_W, 1'b0, 32'h0, 4'b0000, 32'h0);
      send(32'h0000_0001, 32'h2222_2222, SZ_H, 1'b0, 32'h0, 4'b0000, 32'h0);
      send(32'h0000_0000, 32'h3333_3333, SZ_ILL, 1'b0, 32'h0, 4'b0000, 32'h0);
      idle();
      @(negedge clk);
      check("rej_count", 32'(bus.count), 32'(0));
      check("rej_out_valid", 32'(bus.out_valid), 32'(0));
      repeat (2) @(posedge clk);

      // Fill with memory stalled; third store waits for the first pop
      bus.out_ready = 1'b0;
      send(32'h0000_0010, 32'h1111_1111, SZ_W, 1'b1, 32'h0000_0010, 4'b1111, 32'h1111_1111);
      send(32'h0000_0014, 32'h2222_2222, SZ_W, 1'b1, 32'h0000_0014, 4'b1111, 32'h2222_2222);
      fork
         send(32'h0000_0018, 32'h3333_3333, SZ_W, 1'b1, 32'h0000_0018, 4'b1111, 32'h3333_3333);
         begin
            repeat (2) begin
               @(negedge clk);
               check("full_count", 32'(bus.count), 32'(2));
               check("full_in_ready", 32'(bus.in_ready), 32'(0));
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
            @(negedge clk);
            check("full_pop_pending", 32'(bus.count), 32'(2));
            check("full_ready_no_comb", 32'(bus.in_ready), 32'(0));
            @(negedge clk);
            check("after_pop_count", 32'(bus.count), 32'(1));
            check("after_pop_ready", 32'(bus.in_ready), 32'(1));
         end
      join
      idle();
      @(negedge clk);
      check("push_pop_count", 32'(bus.count), 32'(1));
      @(negedge clk);
      check("drained_count", 32'(bus.count), 32'(0));
      @(posedge clk);

      // Sustained push and pop: occupancy stays at one
      fork
         for (int i = 0; i < 8; i++) begin
            send(32'h0000_0200 + 32'(4 * i), 32'hA500_0000 | 32'(i), SZ_W, 1'b1,
                 32'h0000_0200 + 32'(4 * i), 4'b1111, 32'hA500_0000 | 32'(i));
         end
         begin
            @(posedge clk);
            repeat (8) begin
               @(negedge clk);
               check("stream_count", 32'(bus.count), 32'(1));
            end
         end
      join
      idle();
      repeat (3) @(posedge clk);

      // Reset while full discards both entries
      bus.out_ready = 1'b0;
      send(32'h0000_0300, 32'hDEAD_0001, SZ_W, 1'b1, 32'h0000_0300, 4'b1111, 32'hDEAD_0001);
      send(32'h0000_0304, 32'hDEAD_0002, SZ_W, 1'b1, 32'h0000_0304, 4'b1111, 32'hDEAD_0002);
      idle();
      @(negedge clk);
      check("pre_rst_count", 32'(bus.count), 32'(2));
      @(posedge clk);
      #1 reset = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check("midrst_count", 32'(bus.count), 32'(0));
      check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
      check("midrst_in_ready", 32'(bus.in_ready), 32'(0));
      @(posedge clk);
      #1 reset = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_out_valid", 32'(bus.out_valid), 32'(0));
         check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
      end
      @(posedge clk);

      // Fresh store after reset uses lane 2
      send(32'h0000_0002, 32'h1234_565A, SZ_B, 1'b1, 32'h0000_0000, 4'b0100, 32'h5A5A_5A5A);
      idle();

      begin
         int n = 0;
         while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("drain_left", 32'(sb.size()), 32'(0));
      end
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
